alu4_req_scheduler: RTL and testbench
=====================================

Name: alu4_req_scheduler

Overview:
Two-requester front end for the shared 4-bit ALU (add/sub/xor/shl/mul, opcode-selected, registered outputs, multi-cycle multiply).
- Arbitrates between two requesters with valid/ready handshakes.
- Launches one ALU operation at a time with a single-cycle init pulse.
- Waits the operation's fixed latency, captures Y/overflow/zero, and returns them to the owning requester through a valid/ready response channel.
- Sits between bus-side masters (e.g. FSM control unit, test sequencer) and the ALU instance.

Parameters:
N, 4, operand width (must match ALU)
M, 8, result width (must match ALU)
MUL_LAT, 10, cycles after the issue cycle until ALU Y holds the product (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept (one-hot or zero)
req_opcode  in  6  {op1[2:0], op0[2:0]}
req_a  in  2N  {a1, a0}
req_b  in  2N  {b1, b0}
rsp_valid  out  2  one-hot response valid to owner
rsp_ready  in  2  per-requester response ready
rsp_y  out  M  captured result
rsp_ovf  out  1  captured overflow
rsp_zero  out  1  captured zero
rsp_err  out  1  illegal opcode flag
alu_init  out  1  ALU start/capture pulse
alu_opcode  out  3  to ALU
alu_a  out  N  to ALU
alu_b  out  N  to ALU
alu_y  in  M  ALU Y
alu_ovf  in  1  ALU overflow
alu_zero  in  1  ALU zero
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values: state IDLE, rr pointer=0, all outputs 0, rsp_zero=0. Reset mid-operation aborts immediately with no response; the ALU is not reset by this block.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = round-robin over req_valid; pointer favours requester rr.
  - req_ready[g] = grant[g] (combinational, only in IDLE).
  - On valid&ready: latch owner, opcode, a, b.
  - Opcode ≤3'b100 -> ISSUE.
  - Opcode 3'b101..3'b111 -> RESP directly with rsp_y=0, ovf=0, zero=1, err=1; ALU untouched.
- ISSUE: alu_init=1 for exactly this cycle. Load cnt = MUL_LAT-1 for opcode 100, else 0. -> WAIT.
- WAIT:
  - alu_opcode/a/b held stable from ISSUE through the end of WAIT.
  - cnt decrements each cycle.
  - In the cycle with cnt==0: sample alu_y/ovf/zero into response registers, err=0 -> RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_y/ovf/zero/err stable until rsp_ready[owner]=1.
  - On handshake -> IDLE and rr = ~owner.
  - rsp_ready of the non-owner is ignored.
- Latency from accept cycle T: non-MUL rsp_valid at T+3; MUL at T+2+MUL_LAT; illegal at T+1.
- Simultaneous requests: rr pointer chooses. New requests are never accepted while busy; requesters hold valid and data.
- alu_opcode/a/b outputs are 0 when IDLE.

Optional Feature:
ALU4_SCHED_FIXED_PRIO_EN:
- Defined: requester 0 always wins ties; rr pointer not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package alu4_sched_pkg holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_XOR=010, OP_SHL=011, OP_MUL=100
  - state encoding IDLE/ISSUE/WAIT/RESP
  - function is_legal_op
- One sub-module is natural: alu4_rr_arbiter2 (2-way round-robin grant from valid + pointer, with the fixed-priority variant under the macro).
- Bench instantiates the real ALU behind this block.

Test Plan:
- After reset, req0 add a=3 b=4 accepted at T -> alu_init at T+1, rsp_valid=01 at T+3, rsp_y=0x07, ovf=0, zero=0, err=0.
- req1 mul a=7 b=9, MUL_LAT=10 -> rsp_valid=10 at T+12, rsp_y=0x3F, ovf=1; busy high T+1..T+12.
- req0 and req1 both valid from reset with sub 5-5 and xor F^F -> req0 served first (y=0, zero=1); req1 next; on the following tie req0 wins again. With FIXED_PRIO_EN, req0 always wins.
- req0 opcode 110 -> rsp_valid=01 at T+1, err=1, zero=1, y=0, alu_init never pulses.
- rsp_ready low 5 cycles during RESP -> rsp_valid and data held; req1 pending is not accepted until the handshake completes.
- rst asserted during WAIT of a MUL -> next cycle IDLE, all outputs 0, no rsp_valid; a fresh add after reset completes normally.

Source files
------------

// File: rtl/alu4_sched_pkg.sv
// Shared definitions for the two-requester ALU front end.
//   - opcode constants understood by the shared 4-bit ALU
//   - scheduler state encoding
//   - response flag payload
//   - is_legal_op(): opcodes above OP_MUL are rejected without touching the ALU
package alu4_sched_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_SHL = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Flags returned alongside the captured result.
  typedef struct packed {
    logic ovf;
    logic zero;
    logic err;
  } rsp_flags_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu4_rr_arbiter2.sv
// Two-way request arbiter.
//   valid   : per-requester request valid
//   ptr     : requester favoured on a tie (round-robin build only)
//   grant_c : one-hot or zero grant, combinational
// Build option: ALU4_SCHED_FIXED_PRIO_EN makes requester 0 win every tie and
// removes the ptr input.
module alu4_rr_arbiter2 (
  input  logic [1:0] valid,
`ifndef ALU4_SCHED_FIXED_PRIO_EN
  input  logic       ptr,
`endif
  output logic [1:0] grant_c
);

  // A single requester is granted directly; only a tie needs a decision.
  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
`ifdef ALU4_SCHED_FIXED_PRIO_EN
      grant_c = 2'b01;
`else
      grant_c = ptr ? 2'b10 : 2'b01;
`endif
    end
  end

endmodule

// File: rtl/alu4_req_scheduler.sv
// Two-requester front end for the shared 4-bit ALU.
// Accepts one request at a time (valid/ready), launches it on the ALU with a
// one-cycle alu_init pulse, waits the opcode's fixed latency, captures
// Y/overflow/zero and returns them to the owner over a valid/ready response.
// Illegal opcodes (101..111) are answered immediately with err=1.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester request handshake
//   req_opcode/req_a/req_b    {requester1, requester0} operation payloads
//   rsp_valid/rsp_ready       per-requester response handshake
//   rsp_y/ovf/zero/err        captured response, stable while rsp_valid
//   alu_init/opcode/a/b       ALU launch interface
//   alu_y/ovf/zero            ALU registered results
//   busy                      high whenever an operation is in progress
// Build option: ALU4_SCHED_FIXED_PRIO_EN (requester 0 wins ties, no rr pointer).
module alu4_req_scheduler
  import alu4_sched_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 8,
  parameter int unsigned MUL_LAT = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [5:0]     req_opcode,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [M-1:0]   rsp_y,
  output logic           rsp_ovf,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic           alu_init,
  output logic [2:0]     alu_opcode,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [M-1:0]   alu_y,
  input  logic           alu_ovf,
  input  logic           alu_zero,
  output logic           busy
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     y_q, y_d;
  rsp_flags_t       flg_q, flg_d;
  logic [1:0]       grant_c;
  logic [OP_W-1:0]  sel_op;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;

`ifndef ALU4_SCHED_FIXED_PRIO_EN
  logic rr_q, rr_d;
`endif

  alu4_rr_arbiter2 u_arb (
    .valid   (req_valid),
`ifndef ALU4_SCHED_FIXED_PRIO_EN
    .ptr     (rr_q),
`endif
    .grant_c (grant_c)
  );

  // Payload of the granted requester (only meaningful when grant_c != 0).
  assign sel_op = grant_c[1] ? req_opcode[5:3]   : req_opcode[2:0];
  assign sel_a  = grant_c[1] ? req_a[2*N-1:N]    : req_a[N-1:0];
  assign sel_b  = grant_c[1] ? req_b[2*N-1:N]    : req_b[N-1:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      flg_q   <= '0;
`ifndef ALU4_SCHED_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      flg_q   <= flg_d;
`ifndef ALU4_SCHED_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Next-state and output decode; outputs derive from registered state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    flg_d      = flg_q;
`ifndef ALU4_SCHED_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    alu_init   = 1'b0;
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // grant_c is only ever set for a valid requester, so grant == accept.
        req_ready = grant_c;
        if (grant_c != 2'b00) begin
          owner_d = grant_c[1];
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          if (is_legal_op(sel_op)) begin
            state_d = ISSUE;
          end else begin
            y_d       = '0;
            flg_d.ovf  = 1'b0;
            flg_d.zero = 1'b1;
            flg_d.err  = 1'b1;
            state_d   = RESP;
          end
        end
      end

      ISSUE: begin
        alu_init   = 1'b1;
        alu_opcode = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        cnt_d      = (op_q == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        state_d    = WAIT;
      end

      WAIT: begin
        alu_opcode = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        if (cnt_q == '0) begin
          y_d        = alu_y;
          flg_d.ovf  = alu_ovf;
          flg_d.zero = alu_zero;
          flg_d.err  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
`ifndef ALU4_SCHED_FIXED_PRIO_EN
          rr_d    = ~owner_q;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_y    = y_q;
  assign rsp_ovf  = flg_q.ovf;
  assign rsp_zero = flg_q.zero;
  assign rsp_err  = flg_q.err;

endmodule

// File: tb/tb_alu4_req_scheduler.sv
// Bench for alu4_req_scheduler with a behavioural 4-bit ALU behind it.
// A per-cycle reference model tracks the in-flight transaction, the expected
// arbitration winner and the expected response timing.
module tb_alu4_req_scheduler;

  localparam int unsigned N       = 4;
  localparam int unsigned M       = 8;
  localparam int unsigned MUL_LAT = 10;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
    logic       ovf;
    logic       zero;
    logic       err;
  } txn_t;

  typedef struct packed {
    logic r;
    txn_t t;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [5:0] req_opcode = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [7:0] rsp_y;
  logic       rsp_ovf, rsp_zero, rsp_err;
  logic       alu_init;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic [7:0] alu_y = '0;
  logic       alu_ovf = 1'b0;
  logic       alu_zero = 1'b0;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu4_req_scheduler #(.N(N), .M(M), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_init(alu_init), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU arithmetic: returns {ovf, y}.
  function automatic logic [8:0] alu_calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] y;
    logic       o;
    case (op)
      3'b000: begin y = 8'(a) + 8'(b); o = (y > 8'd15); end
      3'b001: begin y = 8'(a) - 8'(b); o = (a < b); end
      3'b010: begin y = 8'(a ^ b); o = 1'b0; end
      3'b011: begin y = 8'(a) << b; o = (y[7:4] != 4'd0); end
      3'b100: begin y = 8'(a) * 8'(b); o = (y > 8'd15); end
      default: begin y = 8'd0; o = 1'b0; end
    endcase
    return {o, y};
  endfunction

  // Behavioural ALU: registered results one cycle after init, product
  // MUL_LAT cycles after init; junk on Y while the multiply is in progress.
  logic [7:0] mcnt = '0;
  logic [8:0] mres = '0;
  always @(posedge clk) begin
    if (alu_init) begin
      if (alu_opcode == 3'b100 && MUL_LAT > 1) begin
        mcnt     <= 8'(MUL_LAT - 1);
        mres     <= alu_calc(alu_opcode, alu_a, alu_b);
        alu_y    <= 8'hEE;
        alu_ovf  <= 1'b0;
        alu_zero <= 1'b0;
      end else begin
        mcnt             <= '0;
        {alu_ovf, alu_y} <= alu_calc(alu_opcode, alu_a, alu_b);
        alu_zero         <= ((alu_calc(alu_opcode, alu_a, alu_b) & 9'h0FF) == 9'h000);
      end
    end else if (mcnt != 8'd0) begin
      mcnt <= mcnt - 8'd1;
      if (mcnt == 8'd1) begin
        {alu_ovf, alu_y} <= mres;
        alu_zero         <= (mres[7:0] == 8'd0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic txn_t with_exp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    txn_t t;
    t.op = op; t.a = a; t.b = b;
    if (op > 3'b100) begin
      t.y = 8'd0; t.ovf = 1'b0; t.zero = 1'b1; t.err = 1'b1;
    end else begin
      {t.ovf, t.y} = alu_calc(op, a, b);
      t.zero = (t.y == 8'd0);
      t.err  = 1'b0;
    end
    return t;
  endfunction

  function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic [7:0] y, input logic o, input logic z, input logic e);
    vec_t v;
    v.r = r; v.t.op = op; v.t.a = a; v.t.b = b;
    v.t.y = y; v.t.ovf = o; v.t.zero = z; v.t.err = e;
    return v;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op > 3'b100) return 1;
    if (op == 3'b100) return 2 + MUL_LAT;
    return 3;
  endfunction

  // Reference model state.
  txn_t q0[$];
  txn_t q1[$];
  txn_t cur;
  bit   pend = 1'b0;
  bit   m_owner = 1'b0;
  bit   last_owner = 1'b1;
  int   acc = 0;
  int   lat = 0;
  int   resp_cycles = 0;
  int   hold = 0;
  bit   rand_rdy = 1'b0;
  bit   order[$];
  int   rsp_len[$];

  function automatic bit tie_winner();
`ifdef ALU4_SCHED_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~last_owner;
`endif
  endfunction

  task automatic model_reset();
    pend = 1'b0; last_owner = 1'b1; resp_cycles = 0;
  endtask

  task automatic drive();
    req_valid  = {1'(q1.size() != 0), 1'(q0.size() != 0)};
    req_opcode = '0; req_a = '0; req_b = '0;
    if (q0.size() != 0) begin
      req_opcode[2:0] = q0[0].op; req_a[3:0] = q0[0].a; req_b[3:0] = q0[0].b;
    end
    if (q1.size() != 0) begin
      req_opcode[5:3] = q1[0].op; req_a[7:4] = q1[0].a; req_b[7:4] = q1[0].b;
    end
    if (rand_rdy) begin
      rsp_ready = 2'($urandom_range(0, 3));
    end else begin
      rsp_ready = 2'b11;
      if (pend && resp_cycles < hold) rsp_ready[m_owner] = 1'b0;
    end
  endtask

  // Compare every DUT output with the model for this cycle, then advance it.
  task automatic step();
    bit         legal, rsp_act;
    logic [1:0] exp_rv, exp_grant;
    logic [10:0] exp_bus;
    legal   = pend && (cur.op <= 3'b100);
    rsp_act = pend && (cyc >= acc + lat);
    exp_rv  = rsp_act ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", 32'(busy), 32'(pend));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (rsp_act)
      chk("rsp_data", 32'({rsp_y, rsp_ovf, rsp_zero, rsp_err}), 32'({cur.y, cur.ovf, cur.zero, cur.err}));
    chk("alu_init", 32'(alu_init), 32'(legal && (cyc == acc + 1)));
    exp_bus = '0;
    if (legal && cyc >= acc + 1 && cyc <= acc + lat - 1) exp_bus = {cur.op, cur.a, cur.b};
    chk("alu_bus", 32'({alu_opcode, alu_a, alu_b}), 32'(exp_bus));
    exp_grant = 2'b00;
    if (!pend) begin
      if (req_valid == 2'b11) exp_grant = tie_winner() ? 2'b10 : 2'b01;
      else exp_grant = req_valid;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_grant));
    if (pend) begin
      if (rsp_act) begin
        resp_cycles++;
        if (rsp_ready[m_owner]) begin
          pend = 1'b0;
          last_owner = m_owner;
          rsp_len.push_back(resp_cycles);
          resp_cycles = 0;
        end
      end
    end else if (exp_grant != 2'b00) begin
      m_owner = exp_grant[1];
      if (m_owner) cur = q1.pop_front();
      else cur = q0.pop_front();
      pend = 1'b1;
      acc  = cyc;
      lat  = lat_of(cur.op);
      order.push_back(m_owner);
    end
  endtask

  task automatic run_engine(input int max_cyc);
    int n;
    n = 0;
    drive();
    while ((q0.size() != 0 || q1.size() != 0 || pend) && n < max_cyc) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      drive();
      n++;
    end
    chk("drain", 32'({pend, q0.size() != 0, q1.size() != 0}), 32'(0));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({nm, "_busy"}, 32'(busy), 32'(0));
    chk({nm, "_alu_init"}, 32'(alu_init), 32'(0));
    chk({nm, "_alu_bus"}, 32'({alu_opcode, alu_a, alu_b}), 32'(0));
    chk({nm, "_rsp_y"}, 32'(rsp_y), 32'(0));
    chk({nm, "_rsp_flags"}, 32'({rsp_ovf, rsp_zero, rsp_err}), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  logic [3:0] exp_order;
  logic [3:0] got_order;

  initial begin
    tbl[0]  = mk(1'b0, 3'b000, 4'h3, 4'h4, 8'h07, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 3'b100, 4'h7, 4'h9, 8'h3F, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 3'b110, 4'h5, 4'h6, 8'h00, 1'b0, 1'b1, 1'b1);
    tbl[3]  = mk(1'b1, 3'b001, 4'h5, 4'h5, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 3'b010, 4'hF, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 3'b011, 4'h3, 4'h2, 8'h0C, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 3'b000, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 3'b001, 4'h2, 4'h5, 8'hFD, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 3'b100, 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 3'b101, 4'h1, 4'h2, 8'h00, 1'b0, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 3'b111, 4'hA, 4'hB, 8'h00, 1'b0, 1'b1, 1'b1);
    tbl[11] = mk(1'b1, 3'b100, 4'h0, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 3'b011, 4'h9, 4'h1, 8'h12, 1'b1, 1'b0, 1'b0);

    // Reset state, during and after reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("idle");
    @(posedge clk); #1;

    // Table-driven single transactions.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].r) q1.push_back(tbl[i].t);
      else q0.push_back(tbl[i].t);
      run_engine(100);
    end

    // Both requesters valid straight out of reset.
    rst = 1'b1;
    model_reset();
    q0.push_back(with_exp(3'b001, 4'h5, 4'h5));
    q0.push_back(with_exp(3'b000, 4'h1, 4'h1));
    q1.push_back(with_exp(3'b010, 4'hF, 4'hF));
    q1.push_back(with_exp(3'b000, 4'h2, 4'h2));
    drive();
    @(posedge clk); #1;
    rst = 1'b0;
    order.delete();
    run_engine(200);
`ifdef ALU4_SCHED_FIXED_PRIO_EN
    exp_order = 4'b0011;
`else
    exp_order = 4'b0101;
`endif
    chk("tie_count", 32'(order.size()), 32'(4));
    if (order.size() == 4) begin
      got_order = {order[0], order[1], order[2], order[3]};
      chk("tie_order", 32'(got_order), 32'(exp_order));
    end

    // Response back-pressure with the other requester pending.
    hold = 5;
    rsp_len.delete();
    q0.push_back(with_exp(3'b000, 4'h6, 4'h7));
    q1.push_back(with_exp(3'b010, 4'h3, 4'h5));
    run_engine(200);
    chk("bp_len0", 32'(rsp_len.size() > 0 ? rsp_len[0] : -1), 32'(6));
    chk("bp_len1", 32'(rsp_len.size() > 1 ? rsp_len[1] : -1), 32'(6));
    hold = 0;

    // Randomized traffic with random response readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(with_exp(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
      q1.push_back(with_exp(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
    end
    run_engine(3000);
    rand_rdy = 1'b0;
    drive();

    // Reset in the middle of a multiply.
    q1.push_back(with_exp(3'b100, 4'h7, 4'h9));
    drive();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step();
      @(posedge clk); #1;
      drive();
    end
    chk("mid_pend", 32'(pend), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    drive();
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      step();
      @(posedge clk); #1;
      drive();
    end
    q0.push_back(with_exp(3'b000, 4'h3, 4'h4));
    run_engine(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
